// File: rtl/sar_search.sv
// Signed successive-approximation search: probes an external less-than comparator MSB first
// and recovers the hidden target. Optional early exit on equality: SAR_SEARCH_EQ_EXIT_EN.
module sar_search #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         lt,
`ifdef SAR_SEARCH_EQ_EXIT_EN
    input  logic         eq,
`endif
    output logic [N-1:0] probe,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_DONE
    } state_t;

    localparam logic [N-1:0] SIGN = {1'b1, {(N-1){1'b0}}};

    state_t       state;
    state_t       state_next;
    logic [N-1:0] code;
    logic [N-1:0] bit_mask;
    logic [N-1:0] code_upd;
    logic         last;
    logic         hit;

    // The search runs on an offset-binary code so a plain MSB-first bit search covers the signed range.
    assign code_upd = lt ? (code & ~bit_mask) : (code | bit_mask);
    assign last     = bit_mask[0];

`ifdef SAR_SEARCH_EQ_EXIT_EN
    assign hit = eq;
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            ST_IDLE:   if (start) state_next = ST_SEARCH;
            ST_SEARCH: if (hit || last) state_next = ST_DONE;
            ST_DONE:   state_next = start ? ST_SEARCH : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_SEARCH);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code     <= '0;
            bit_mask <= '0;
            probe    <= '0;
            result   <= '0;
        end else begin
            unique case (state)
                ST_SEARCH: begin
                    if (hit) begin
                        result   <= probe;
                        probe    <= '0;
                        bit_mask <= '0;
                    end else if (last) begin
                        code     <= code_upd;
                        result   <= code_upd ^ SIGN;
                        probe    <= '0;
                        bit_mask <= '0;
                    end else begin
                        code     <= code_upd;
                        bit_mask <= bit_mask >> 1;
                        probe    <= (code_upd | (bit_mask >> 1)) ^ SIGN;
                    end
                end
                default: begin
                    // First trial (code 0, MSB set) maps back to a probe of 0.
                    probe <= '0;
                    if (start) begin
                        code     <= '0;
                        bit_mask <= SIGN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Scoreboard bench for sar_search at N=8 and N=32 against behavioural comparators.
module tb_sar_search;

    logic        clk;
    logic        rst;
    logic        start8;
    logic        start32;
    logic [7:0]  t8;
    logic [31:0] t32;
    logic        lt8, lt32;
    logic        eq8, eq32;
    logic [7:0]  p8, r8;
    logic [31:0] p32, r32;
    logic        busy8, done8, busy32, done32;

    int checks = 0;
    int errors = 0;

    logic [7:0]  sb8[$];
    logic [31:0] sb32[$];
    logic [7:0]  plog8[8];

    assign lt8  = $signed(t8) < $signed(p8);
    assign eq8  = (t8 == p8);
    assign lt32 = $signed(t32) < $signed(p32);
    assign eq32 = (t32 == p32);

    sar_search #(.N(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .lt    (lt8),
`ifdef SAR_SEARCH_EQ_EXIT_EN
        .eq    (eq8),
`endif
        .probe (p8),
        .busy  (busy8),
        .done  (done8),
        .result(r8)
    );

    sar_search #(.N(32)) dut32 (
        .clk   (clk),
        .rst   (rst),
        .start (start32),
        .lt    (lt32),
`ifdef SAR_SEARCH_EQ_EXIT_EN
        .eq    (eq32),
`endif
        .probe (p32),
        .busy  (busy32),
        .done  (done32),
        .result(r32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Trial for bit i of an n-bit search: target's offset-binary bits above i, a one at i, zeros below.
    function automatic logic [31:0] exp_probe(input logic [31:0] t, input int n, input int i);
        logic [31:0] s, u, r;
        s = 32'h1 << (n - 1);
        u = t ^ s;
        r = '0;
        for (int b = 0; b < n; b++) begin
            if (b > i) r[b] = u[b];
            else if (b == i) r[b] = 1'b1;
        end
        return r ^ s;
    endfunction

    // Called on a negedge with the DUT idle or in DONE; returns on the negedge of the done cycle.
    task automatic search8(input logic [7:0] t, input bit hold, output int lat);
        logic [31:0] ep;
        logic [7:0]  exp_res;
        int          exp_lat;
        int          k;
        t8     = t;
        start8 = 1'b1;
        sb8.push_back(t);
        exp_lat = 9;
`ifdef SAR_SEARCH_EQ_EXIT_EN
        for (int j = 1; j <= 8; j++) begin
            ep = exp_probe({24'b0, t}, 8, 8 - j);
            if (ep[7:0] == t) begin
                exp_lat = j + 1;
                break;
            end
        end
`endif
        k   = 0;
        lat = -1;
        while (lat < 0) begin
            @(negedge clk);
            k++;
            if (!hold) start8 = 1'b0;
            if (done8) begin
                lat = k;
            end else if (k > 12) begin
                checks++;
                errors++;
                $display("FAIL timeout8: no done after %0d cycles, required %0d", k, exp_lat);
                lat = k;
            end else begin
                checks++;
                if (busy8 !== 1'b1) begin
                    errors++;
                    $display("FAIL busy8 cycle %0d: got %b required 1", k, busy8);
                end
                if (k <= 8) begin
                    ep = exp_probe({24'b0, t}, 8, 8 - k);
                    plog8[k-1] = p8;
                    checks++;
                    if (p8 !== ep[7:0]) begin
                        errors++;
                        $display("FAIL probe8 cycle %0d: got %0d required %0d", k, $signed(p8), $signed(ep[7:0]));
                    end
                end
            end
        end
        checks++;
        if (busy8 !== 1'b0 || p8 !== 8'd0) begin
            errors++;
            $display("FAIL done_state8: busy %b probe %0d, required busy 0 probe 0", busy8, p8);
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL latency8: got %0d required %0d", lat, exp_lat);
        end
        checks++;
        if (sb8.size() == 0) begin
            errors++;
            $display("FAIL scoreboard8: done with empty queue, result %0d", $signed(r8));
        end else begin
            exp_res = sb8.pop_front();
            if (r8 !== exp_res) begin
                errors++;
                $display("FAIL result8: got %0d required %0d", $signed(r8), $signed(exp_res));
            end
        end
    endtask

    task automatic search32(input logic [31:0] t);
        logic [31:0] ep;
        logic [31:0] exp_res;
        int          exp_lat;
        int          k;
        bit          fin;
        t32     = t;
        start32 = 1'b1;
        sb32.push_back(t);
        exp_lat = 33;
`ifdef SAR_SEARCH_EQ_EXIT_EN
        for (int j = 1; j <= 32; j++) begin
            ep = exp_probe(t, 32, 32 - j);
            if (ep == t) begin
                exp_lat = j + 1;
                break;
            end
        end
`endif
        k   = 0;
        fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            k++;
            start32 = 1'b0;
            if (done32) fin = 1'b1;
            else if (k > 40) begin
                checks++;
                errors++;
                $display("FAIL timeout32: no done after %0d cycles", k);
                fin = 1'b1;
            end
        end
        checks++;
        if (k != exp_lat || busy32 !== 1'b0) begin
            errors++;
            $display("FAIL latency32: got %0d busy %b, required %0d busy 0", k, busy32, exp_lat);
        end
        checks++;
        if (sb32.size() == 0) begin
            errors++;
            $display("FAIL scoreboard32: done with empty queue");
        end else begin
            exp_res = sb32.pop_front();
            if (r32 !== exp_res) begin
                errors++;
                $display("FAIL result32: got %0d required %0d", $signed(r32), $signed(exp_res));
            end
        end
        @(negedge clk);
    endtask

    task automatic check_idle8(input string name);
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 8'd0) begin
            errors++;
            $display("FAIL %s: busy %b done %b probe %0d, required all 0", name, busy8, done8, p8);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 8'd0 || r8 !== 8'd0) begin
            errors++;
            $display("FAIL reset8: busy %b done %b probe %0d result %0d, required 0", busy8, done8, p8, r8);
        end
        checks++;
        if (busy32 !== 1'b0 || done32 !== 1'b0 || p32 !== 32'd0 || r32 !== 32'd0) begin
            errors++;
            $display("FAIL reset32: busy %b done %b probe %0d result %0d, required 0", busy32, done32, p32, r32);
        end
        rst = 1'b1;
        @(negedge clk);
        check_idle8("idle_after_reset");
    endtask

    task automatic test_basic();
        logic [7:0] tbl[8];
        int lat;
        tbl = '{8'd0, 8'd64, 8'd32, 8'd48, 8'd40, 8'd36, 8'd38, 8'd37};
        search8(8'd37, 1'b0, lat);
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (plog8[j] !== tbl[j]) begin
                errors++;
                $display("FAIL seq37 probe %0d: got %0d required %0d", j, plog8[j], tbl[j]);
            end
        end
`ifndef SAR_SEARCH_EQ_EXIT_EN
        checks++;
        if (lat != 9) begin
            errors++;
            $display("FAIL done_cycle37: got %0d required 9", lat);
        end
`endif
        @(negedge clk);
        check_idle8("idle_after_37");
    endtask

    task automatic test_extremes();
        logic [7:0] tv[3];
        int lat;
        tv = '{8'h80, 8'h7F, 8'hFF};
        foreach (tv[j]) begin
            search8(tv[j], 1'b0, lat);
            @(negedge clk);
        end
        checks++;
        if (plog8[1] !== 8'hC0 || plog8[2] !== 8'hE0) begin
            errors++;
            $display("FAIL seq_minus1: probes %0d %0d required -64 -32", $signed(plog8[1]), $signed(plog8[2]));
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        search8(8'd5, 1'b1, lat);
        search8(8'hB3, 1'b1, lat);
`ifndef SAR_SEARCH_EQ_EXIT_EN
        checks++;
        if (lat != 9) begin
            errors++;
            $display("FAIL b2b_period: got %0d required 9", lat);
        end
`endif
        start8 = 1'b0;
        @(negedge clk);
        check_idle8("idle_after_b2b");
    endtask

    task automatic test_abort();
        t8     = 8'd99;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy8 !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: busy got %b required 1", busy8);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 8'd0 || r8 !== 8'd0) begin
            errors++;
            $display("FAIL abort: busy %b done %b probe %0d result %0d, required 0", busy8, done8, p8, r8);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle8("idle_after_abort");
        begin
            int lat;
            search8(8'd12, 1'b0, lat);
        end
        @(negedge clk);
    endtask

`ifdef SAR_SEARCH_EQ_EXIT_EN
    task automatic test_eq_exit();
        int lat;
        search8(8'd0, 1'b0, lat);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL eq_zero_cycle: got %0d required 2", lat);
        end
        @(negedge clk);
        search8(8'd64, 1'b0, lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL eq_64_cycle: got %0d required 3", lat);
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_random32();
        search32(32'h8000_0000);
        search32(32'h7FFF_FFFF);
        for (int n = 0; n < 1000; n++) search32($urandom());
    endtask

    initial begin
        rst     = 1'b0;
        start8  = 1'b0;
        start32 = 1'b0;
        t8      = '0;
        t32     = '0;
        test_reset();
        test_basic();
        test_extremes();
        test_back_to_back();
        test_abort();
`ifdef SAR_SEARCH_EQ_EXIT_EN
        test_eq_exit();
`endif
        test_random32();
        checks++;
        if (sb8.size() != 0 || sb32.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d/%0d left, required 0", sb8.size(), sb32.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
